mem_sram_controller: RTL and testbench

//  Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM.
//  - Accepts one 32-bit word read or write from the MEM stage.
//  - Performs it as two half-word SRAM accesses: low half first, then high half.
//  - Drives ready low while busy; the pipeline uses ~ready as its global freeze.

---
 rtl/arm_mem_pkg.sv | 17 +
 rtl/mem_sram_controller.sv | 151 +++++++++++++++
 tb/tb_mem_sram_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared constants and state encoding for the MEM-stage SRAM controller.
package arm_mem_pkg;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned SRAM_DATA_W   = 16;
  localparam int unsigned WORD_W        = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD_LO = 3'd1;
  localparam state_t ST_RD_HI = 3'd2;
  localparam state_t ST_WR_LO = 3'd3;
  localparam state_t ST_WR_HI = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/mem_sram_controller.sv
// Splits one 32-bit MEM-stage access into two 16-bit asynchronous SRAM accesses
// (low half, then high half) and freezes the pipeline through ready while busy.
module mem_sram_controller
  import arm_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned HALF_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [WORD_W-1:0]       address,
  input  logic [WORD_W-1:0]       write_data,
  output logic [WORD_W-1:0]       read_data,
  output logic                    ready,
  output logic [SRAM_ADDR_W-1:0]  sram_addr,
  input  logic [SRAM_DATA_W-1:0]  sram_dq_in,
  output logic [SRAM_DATA_W-1:0]  sram_dq_out,
  output logic                    sram_dq_oe,
  output logic                    sram_we_n
);

  localparam int unsigned WORD_AW = SRAM_ADDR_W - 1;
  localparam int unsigned CNT_W   = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [WORD_AW-1:0]       r_word;
  logic [WORD_W-1:0]        r_wdata;
  logic [SRAM_DATA_W-1:0]   r_lo;
  logic [WORD_W-1:0]        r_read_data;
  logic [SRAM_ADDR_W-1:0]   r_sram_addr;
  logic [SRAM_DATA_W-1:0]   r_sram_dq_out;
  logic                     r_sram_dq_oe;
  logic                     r_sram_we_n;

  logic                     w_req;
  logic                     w_last;
  logic [WORD_W-1:0]        w_offset;
  logic [WORD_AW-1:0]       w_word;

  assign w_req    = rd_en | wr_en;
  assign w_last   = (r_cnt == CNT_LAST);
  // Out-of-range addresses wrap simply by dropping the high word bits.
  assign w_offset = address - WORD_W'(BASE_ADDR);
  assign w_word   = WORD_AW'(w_offset >> 2);

  assign read_data   = r_read_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_sram_dq_out;
  assign sram_dq_oe  = r_sram_dq_oe;
  assign sram_we_n   = r_sram_we_n;

  always_comb begin
    ready = 1'b0;
    case (r_state)
      ST_IDLE: ready = ~w_req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Request copies and the low-half read buffer need no reset: they are
  // always rewritten before being used.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_req) begin
      r_word  <= w_word;
      r_wdata <= write_data;
    end
    if (r_state == ST_RD_LO && w_last) begin
      r_lo <= sram_dq_in;
    end
  end

  // SRAM bus signals are registered so each phase presents stable strobes
  // from its first cycle to its last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_read_data   <= '0;
      r_sram_addr   <= '0;
      r_sram_dq_out <= '0;
      r_sram_dq_oe  <= 1'b0;
      r_sram_we_n   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_sram_addr <= {w_word, 1'b0};
            if (wr_en) begin
              r_state       <= ST_WR_LO;
              r_sram_dq_out <= write_data[SRAM_DATA_W-1:0];
              r_sram_dq_oe  <= 1'b1;
              r_sram_we_n   <= 1'b0;
            end else begin
              r_state <= ST_RD_LO;
            end
          end
        end
        ST_RD_LO: begin
          if (w_last) begin
            r_cnt       <= '0;
            r_sram_addr <= {r_word, 1'b1};
            r_state     <= ST_RD_HI;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RD_HI: begin
          if (w_last) begin
            r_cnt       <= '0;
            r_read_data <= {sram_dq_in, r_lo};
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_WR_LO: begin
          if (w_last) begin
            r_cnt         <= '0;
            r_sram_addr   <= {r_word, 1'b1};
            r_sram_dq_out <= r_wdata[WORD_W-1:SRAM_DATA_W];
            r_state       <= ST_WR_HI;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_WR_HI: begin
          if (w_last) begin
            r_cnt        <= '0;
            r_sram_dq_oe <= 1'b0;
            r_sram_we_n  <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        // Requests still asserted here belong to the next instruction.
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Bench for mem_sram_controller: directed vector table, hand sequences for
// back-to-back and reset corners, then random traffic against a word-level model.
module tb_mem_sram_controller;
  import arm_mem_pkg::*;

  localparam int HC = 2;
  localparam int AW = 18;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [AW-1:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;

  mem_sram_controller #(
    .BASE_ADDR(1024),
    .SRAM_ADDR_W(AW),
    .HALF_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .address(address),
    .write_data(write_data),
    .read_data(read_data),
    .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_in(sram_dq_in),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Half-word SRAM: writes land on clock edges while we_n is low, reads are
  // presented from the current address each cycle.
  logic [15:0] sram_mem [int];
  initial sram_dq_in = 16'h0;
  always @(posedge clk) begin
    if (rst && !sram_we_n) sram_mem[int'(sram_addr)] = sram_dq_out;
  end
  always @(negedge clk) begin
    sram_dq_in = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int          o_lat;
  logic        o_req_ready;
  logic        o_hold_ok;
  logic [AW-1:0] o_alo, o_ahi;
  logic [15:0] o_dlo, o_dhi;
  logic [1:0]  o_slo, o_shi, o_sdone;
  logic [31:0] o_rdata;

  task automatic run_access(input logic wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wd);
    logic [35:0] snap;
    snap = '0;
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = addr; write_data = wd;
    @(negedge clk);
    o_req_ready = ready;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
    o_hold_ok = 1'b1;
    o_lat = -1;
    for (int cyc = 1; cyc <= 4*HC + 8; cyc++) begin
      @(negedge clk);
      if (ready) begin
        o_lat = cyc;
        break;
      end
      if (cyc == 1 || cyc == HC + 1)
        snap = {sram_addr, sram_dq_out, sram_dq_oe, sram_we_n};
      else if (snap !== {sram_addr, sram_dq_out, sram_dq_oe, sram_we_n})
        o_hold_ok = 1'b0;
      if (cyc == 1) begin
        o_alo = sram_addr; o_dlo = sram_dq_out; o_slo = {sram_dq_oe, sram_we_n};
      end
      if (cyc == HC + 1) begin
        o_ahi = sram_addr; o_dhi = sram_dq_out; o_shi = {sram_dq_oe, sram_we_n};
      end
    end
    o_rdata = read_data;
    o_sdone = {sram_dq_oe, sram_we_n};
  endtask

  task automatic check_access(input string tag, input logic wr, input logic rd,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [AW-1:0] exp_alo, input logic [31:0] exp_rdata);
    logic [1:0] exp_strb;
    exp_strb = wr ? 2'b10 : 2'b01;
    run_access(wr, rd, addr, wd);
    chk({tag, ".req_ready"}, 64'(o_req_ready), 64'(0));
    chk({tag, ".latency"}, 64'(o_lat), 64'(2*HC + 1));
    chk({tag, ".addr_lo"}, 64'(o_alo), 64'(exp_alo));
    chk({tag, ".addr_hi"}, 64'(o_ahi), 64'(exp_alo | 1));
    chk({tag, ".hold"}, 64'(o_hold_ok), 64'(1));
    chk({tag, ".strb_lo"}, 64'(o_slo), 64'(exp_strb));
    chk({tag, ".strb_hi"}, 64'(o_shi), 64'(exp_strb));
    chk({tag, ".strb_done"}, 64'(o_sdone), 64'(2'b01));
    if (wr) begin
      chk({tag, ".dq_lo"}, 64'(o_dlo), 64'(wd[15:0]));
      chk({tag, ".dq_hi"}, 64'(o_dhi), 64'(wd[31:16]));
    end
    chk({tag, ".rdata"}, 64'(o_rdata), 64'(exp_rdata));
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [AW-1:0] alo;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] ref_mem [int];
  logic [31:0] ref_rdata;

  initial begin
    logic [11:0] pat;
    logic        idle_ok;
    vecs[0] = '{1'b1, 1'b0, 32'd1028,    32'hDEADBEEF, 18'd2,       32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'd1028,    32'h0,        18'd2,       32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1024,    32'h1,        18'd0,       32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 32'd1024,    32'h0,        18'd0,       32'h1};
    vecs[4] = '{1'b1, 1'b0, 32'h00080408, 32'h12345678, 18'd4,      32'h1};
    vecs[5] = '{1'b0, 1'b1, 32'd1032,    32'h0,        18'd4,       32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 32'd1029,    32'h0,        18'd2,       32'hDEADBEEF};
    vecs[7] = '{1'b0, 1'b1, 32'h00080400, 32'h0,       18'd0,       32'h1};
    vecs[8] = '{1'b1, 1'b0, 32'd1020,    32'hAAAA5555, 18'h3FFFE,   32'h1};
    vecs[9] = '{1'b0, 1'b1, 32'd1020,    32'h0,        18'h3FFFE,   32'hAAAA5555};

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    chk("reset.read_data", 64'(read_data), 64'(0));
    chk("reset.sram_addr", 64'(sram_addr), 64'(0));
    chk("reset.dq_out", 64'(sram_dq_out), 64'(0));
    chk("reset.strobes", 64'({sram_dq_oe, sram_we_n}), 64'(2'b01));
    chk("reset.ready", 64'(ready), 64'(1));
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      check_access($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr,
                   vecs[i].wd, vecs[i].alo, vecs[i].rdata);

    // Back-to-back reads with rd_en held: second access reads another word.
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'd1028;
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      pat[k] = ready;
      if (k == 5) begin
        chk("b2b.rdata1", 64'(read_data), 64'(32'hDEADBEEF));
        @(posedge clk); #1;
        address = 32'd1032;
      end
      if (k == 7) chk("b2b.addr2", 64'(sram_addr), 64'(4));
      if (k == 11) chk("b2b.rdata2", 64'(read_data), 64'(32'h12345678));
    end
    chk("b2b.ready_pattern", 64'(pat), 64'(12'h820));
    @(posedge clk); #1;
    rd_en = 1'b0;

    // Reset during the low write phase aborts the access.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    @(negedge clk);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("rst.in_wr_lo", 64'(sram_we_n), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst.strobes", 64'({sram_dq_oe, sram_we_n}), 64'(2'b01));
    chk("rst.ready", 64'(ready), 64'(1));
    chk("rst.read_data", 64'(read_data), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    idle_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (!(ready && sram_we_n && !sram_dq_oe)) idle_ok = 1'b0;
    end
    chk("rst.idle_after", 64'(idle_ok), 64'(1));
    chk("rst.no_write", 64'(sram_mem.exists(8) || sram_mem.exists(9)), 64'(0));

    // Random traffic over words 16..31, with optional address wrap.
    ref_rdata = 32'h0;
    for (int i = 0; i < 40; i++) begin
      int unsigned op, w;
      logic [31:0] a, d, exp;
      logic wr, rd;
      op = $urandom_range(0, 3);
      w  = 16 + $urandom_range(0, 15);
      a  = BASE + 32'(w * 4) + 32'($urandom_range(0, 3)) + 32'($urandom_range(0, 1) << (AW + 1));
      d  = $urandom;
      wr = (op >= 2);
      rd = (op != 2);
      if (wr) begin
        ref_mem[int'(w)] = d;
        exp = ref_rdata;
      end else begin
        exp = ref_mem.exists(int'(w)) ? ref_mem[int'(w)] : 32'h0;
        ref_rdata = exp;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      check_access($sformatf("rnd%0d", i), wr, rd, a, d, AW'(w * 2), exp);
      if (wr)
        chk($sformatf("rnd%0d.sram_word", i),
            64'({sram_mem[int'(w*2+1)], sram_mem[int'(w*2)]}), 64'(d));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
